mem_wait_injector: RTL and testbench

MEM_WAIT_INJECTOR -- requirements
Module: mem_wait_injector

---
 rtl/mem_wait_injector.sv | 108 ++++++++++
 tb/tb_mem_wait_injector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_injector.sv
// mem_wait_injector: picorv32 native-bus shim that inserts configurable wait states
// ahead of a single-cycle backend access and reports transaction/stall counts.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

module mem_wait_injector #(
    parameter int          BUS_W     = `SIZE_OF_THE_BUS,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [BUS_W-1:0] mem_addr,
    input  logic [BUS_W-1:0] mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [BUS_W-1:0] mem_rdata,
    output logic             bk_req,
    output logic [3:0]       bk_wstrb,
    output logic [BUS_W-1:0] bk_addr,
    output logic [BUS_W-1:0] bk_wdata,
    input  logic [BUS_W-1:0] bk_rdata,
    input  logic [1:0]       wait_mode,
    input  logic [2:0]       wait_fixed,
    output logic [31:0]      txn_count,
    output logic [31:0]      stall_count
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t           state;
    logic [2:0]       w;
    logic [2:0]       w_new;
    logic [15:0]      lfsr;
    logic [BUS_W-1:0] addr_q;
    logic [BUS_W-1:0] wdata_q;
    logic [3:0]       wstrb_q;

    always_comb begin
        w_new = wait_mode == 2'd0 ? 3'd0 :
                wait_mode == 2'd1 ? wait_fixed :
                (wait_mode == 2'd2 || mem_instr) ? lfsr[2:0] : 3'd0;
        mem_rdata = (state == RESP && wstrb_q == 4'd0) ? bk_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            w           <= 3'd0;
            lfsr        <= LFSR_SEED;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 4'd0;
            mem_ready   <= 1'b0;
            bk_req      <= 1'b0;
            bk_wstrb    <= 4'd0;
            bk_addr     <= '0;
            bk_wdata    <= '0;
            txn_count   <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            bk_req    <= 1'b0;
            bk_wstrb  <= 4'd0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: if (mem_valid) begin
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    wstrb_q <= mem_wstrb;
                    w       <= w_new;
                    if (w_new == 3'd0) begin
                        state    <= ACCESS;
                        bk_req   <= 1'b1;
                        bk_wstrb <= mem_wstrb;
                        bk_addr  <= mem_addr;
                        bk_wdata <= mem_wdata;
                    end else begin
                        state <= WAIT;
                    end
                end
                // Core withdrawing its request while we stall cancels it outright
                WAIT: if (!mem_valid) begin
                    state <= IDLE;
                end else begin
                    stall_count <= stall_count + 32'd1;
                    w           <= w - 3'd1;
                    if (w == 3'd1) begin
                        state    <= ACCESS;
                        bk_req   <= 1'b1;
                        bk_wstrb <= wstrb_q;
                        bk_addr  <= addr_q;
                        bk_wdata <= wdata_q;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    mem_ready <= 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    txn_count <= txn_count + 32'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wait_injector.sv
// tb_mem_wait_injector: directed and randomized checks of mem_wait_injector against
// a backend memory, a scoreboard memory and a software wait-state model.
module tb_mem_wait_injector;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bk_req;
    logic [3:0]  bk_wstrb;
    logic [31:0] bk_addr;
    logic [31:0] bk_wdata;
    logic [31:0] bk_rdata = '0;
    logic [1:0]  wait_mode = '0;
    logic [2:0]  wait_fixed = '0;
    logic [31:0] txn_count;
    logic [31:0] stall_count;

    mem_wait_injector #(.BUS_W(32), .LFSR_SEED(SEED)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bk_req(bk_req),
        .bk_wstrb(bk_wstrb), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
        .bk_rdata(bk_rdata), .wait_mode(wait_mode), .wait_fixed(wait_fixed),
        .txn_count(txn_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int bk_reqs = 0;
    int readies = 0;
    int txn_exp = 0;
    logic [31:0] stall_exp = '0;
    logic [31:0] bmem [256];
    logic [31:0] ref_mem [256];
    logic [15:0] m_lfsr = SEED;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11], s[15:1]};
    endfunction

    always @(posedge clk) m_lfsr <= !resetn ? SEED : lfsr_step(m_lfsr);

    // Backend memory: write on strobe, return read data for the following cycle
    always @(negedge clk) begin
        if (mem_ready) readies++;
        if (bk_req) begin
            bk_reqs++;
            if (bk_wstrb != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (bk_wstrb[b]) bmem[bk_addr[9:2]][8*b +: 8] = bk_wdata[8*b +: 8];
            end else begin
                bk_rdata = bmem[bk_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [1:0] mode, input logic [2:0] wf,
                       input bit scramble);
        int k = 0;
        int bkc = -1;
        int n0;
        logic [2:0] exp_w;
        logic [31:0] exp_rd;
        @(negedge clk);
        exp_w = mode == 2'd0 ? 3'd0 : mode == 2'd1 ? wf :
                (mode == 2'd2 || instr) ? m_lfsr[2:0] : 3'd0;
        exp_rd = ref_mem[addr[9:2]];
        n0 = bk_reqs;
        mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wdata = wdata;
        mem_wstrb = wstrb; wait_mode = mode; wait_fixed = wf;
        while (!mem_ready && k < 40) begin
            @(negedge clk);
            k++;
            if (bk_req) begin
                bkc = k;
                chk("bk_addr", bk_addr, addr);
                chk("bk_wdata", bk_wdata, wdata);
                chk("bk_wstrb", {28'd0, bk_wstrb}, {28'd0, wstrb});
            end
            if (scramble) begin
                mem_addr = $urandom; mem_wdata = $urandom;
                mem_wstrb = 4'($urandom); wait_mode = 2'($urandom); wait_fixed = 3'($urandom);
            end
        end
        chk("latency", 32'(k), 32'(2 + int'(exp_w)));
        chk("bk_cycle", 32'(bkc), 32'(1 + int'(exp_w)));
        chk("bk_count", 32'(bk_reqs - n0), 32'd1);
        chk("rdata", mem_rdata, wstrb == 4'd0 ? exp_rd : 32'd0);
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
        stall_exp += 32'(exp_w);
        txn_exp++;
        mem_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_rdata"}, mem_rdata, 32'd0);
        chk({tag, "_bk_req"}, {31'd0, bk_req}, 32'd0);
        chk({tag, "_bk_wstrb"}, {28'd0, bk_wstrb}, 32'd0);
        chk({tag, "_bk_addr"}, bk_addr, 32'd0);
        chk({tag, "_bk_wdata"}, bk_wdata, 32'd0);
        chk({tag, "_txn"}, txn_count, 32'd0);
        chk({tag, "_stall"}, stall_count, 32'd0);
    endtask

    initial begin
        int n0;
        int r0;
        for (int i = 0; i < 256; i++) begin bmem[i] = '0; ref_mem[i] = '0; end
        bmem[8'h40] = 32'hDEADBEEF;
        ref_mem[8'h40] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        resetn = 1'b1;

        txn(1'b0, 32'h100, 32'h0, 4'h0, 2'd0, 3'd0, 1'b0);
        @(negedge clk);
        chk("m0_txn", txn_count, 32'd1);

        txn(1'b0, 32'h200, 32'h12345678, 4'hF, 2'd1, 3'd5, 1'b0);
        @(negedge clk);
        chk("m1_stall", stall_count, 32'd5);
        txn(1'b0, 32'h200, 32'h0, 4'h0, 2'd0, 3'd0, 1'b0);

        txn(1'b1, 32'h300, 32'h0, 4'h0, 2'd3, 3'd0, 1'b0);
        txn(1'b0, 32'h200, 32'h0, 4'h0, 2'd3, 3'd0, 1'b0);
        @(negedge clk);
        chk("m3_txn", txn_count, 32'(txn_exp));
        chk("m3_stall", stall_count, stall_exp);

        // Reset landing in the middle of a fixed 7-cycle wait
        n0 = bk_reqs; r0 = readies;
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h3F0; mem_wdata = 32'hA5A5A5A5;
        mem_wstrb = 4'h3; wait_mode = 2'd1; wait_fixed = 3'd7;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        mem_valid = 1'b0; resetn = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_bk", 32'(bk_reqs - n0), 32'd0);
        chk("midrst_no_ready", 32'(readies - r0), 32'd0);
        txn_exp = 0; stall_exp = '0;

        // Request withdrawn while stalling
        txn(1'b0, 32'h10, 32'h0, 4'h0, 2'd0, 3'd0, 1'b0);
        @(negedge clk);
        n0 = bk_reqs; r0 = readies;
        mem_valid = 1'b1; mem_addr = 32'h44; mem_wstrb = 4'h0; wait_mode = 2'd1; wait_fixed = 3'd4;
        repeat (2) @(negedge clk);
        mem_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_bk", 32'(bk_reqs - n0), 32'd0);
        chk("abort_no_ready", 32'(readies - r0), 32'd0);
        chk("abort_txn", txn_count, 32'(txn_exp));
        txn(1'b0, 32'h44, 32'h0, 4'h0, 2'd0, 3'd0, 1'b0);

        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        txn_exp = 0; stall_exp = '0;
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] s;
            s = $urandom_range(0, 1) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
            txn(1'($urandom), {22'd0, 8'($urandom), 2'b00}, $urandom, s, 2'd2, 3'($urandom), 1'b1);
        end
        @(negedge clk);
        chk("rand_txn", txn_count, 32'd1000);
        chk("rand_stall", stall_count, stall_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
